psum_gbf_ctrl: RTL and testbench
================================

# psum_gbf_ctrl

Sequencing controller for the double-buffered partial-sum global buffer (`psum_gbf_wrapper`). It zeroes both banks after reset and walks the su_adder accumulation stream through a configurable number of addresses and passes per tile. It then swaps the ping-pong banks and drains the finished bank to the downstream consumer, zeroing each entry behind the read. Accumulation of tile k+1 overlaps the drain of tile k.

## Interface
- `PSUM_GBF_ADDR_BITWIDTH`, default 5: psum gbf address width.
- `PSUM_GBF_DEPTH`, default 32: entries per bank.
- `PASS_BITWIDTH`, default 8: width of the pass and tile counts.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `cfg_valid`  in  1: job configuration valid.
- `cfg_ready`  out  1: controller idle; accepts a job.
- `cfg_num_addr`  in  PSUM_GBF_ADDR_BITWIDTH+1: psum entries used per tile.
- `cfg_num_pass`  in  PASS_BITWIDTH: accumulation passes per tile.
- `cfg_num_tile`  in  PASS_BITWIDTH: tiles per job.
- `acc_valid`  in  1: su_adder presents one psum word.
- `acc_ready`  out  1: word is accepted when `acc_valid & acc_ready`.
- `psum_gbf_w_en`  out  1: accumulate strobe to the wrapper.
- `psum_gbf_w_addr`  out  PSUM_GBF_ADDR_BITWIDTH: accumulate address.
- `psum_gbf_w_num`  out  1: accumulating bank select. 0 = bank1 accumulates and bank2 drains/inits; 1 = the reverse.
- `psum_gbf_r_en`  out  1: drain read strobe.
- `psum_gbf_r_addr`  out  PSUM_GBF_ADDR_BITWIDTH: drain read address.
- `psum_gbf_w_en_for_init`  out  1: zero-write strobe to the drain-side bank.
- `psum_gbf_w_addr_for_init`  out  PSUM_GBF_ADDR_BITWIDTH: zero-write address.
- `drain_ready`  in  1: downstream can take a word two cycles later.
- `drain_valid`  out  1: drained bank read data is valid this cycle.
- `drain_last`  out  1: with `drain_valid`, last word of a tile.
- `done`  out  1: one-cycle pulse when the job's final tile is drained and zeroed.

## Operation
- **Config clamping.** `cfg_num_addr` is clamped to the range [1, PSUM_GBF_DEPTH]. A value of 0 in `cfg_num_pass` or `cfg_num_tile` is treated as 1. All config is latched on the accept handshake.
- **Accumulate FSM: `A_INIT1` → `A_INIT2` → `A_IDLE` → `A_ACC` → `A_WAIT` → (`A_ACC` | `A_IDLE`).**
  - `A_INIT1`: `w_num`=1. Zero-write addresses 0..DEPTH-1 via the for_init port (bank1), one per cycle.
  - `A_INIT2`: `w_num`=0. Same sweep zeroes bank2.
  - `A_IDLE`: `cfg_ready`=1 only when the drain FSM is also `D_IDLE`.
  - `A_ACC`: `acc_ready`=1. Each handshake gives `psum_gbf_w_en`=1 and `w_addr`=addr counter. The address wraps at num_addr-1 and increments the pass counter. After the last address of the last pass, go to `A_WAIT`.
  - `A_WAIT`: swap when the drain FSM is `D_IDLE`. On swap, toggle `w_num`, start the drain, and increment the tile counter. Next state is `A_ACC` if tiles remain, else `A_IDLE`.
- **Drain FSM: `D_IDLE` → `D_DRAIN` → `D_FLUSH` → `D_IDLE`.**
  - `D_DRAIN`: each cycle with `drain_ready`=1, `r_en`=1 and `r_addr`=drain counter. The read is held while `drain_ready`=0. After address num_addr-1 is issued, go to `D_FLUSH`.
  - `D_FLUSH`: wait for the pipeline to empty.
- **Read-before-zero.** The zero-write for an address is the read strobe delayed by one cycle: `w_en_for_init`=r_en delayed, `w_addr_for_init`=r_addr delayed.
- **Drain data handshake.** `drain_valid` is `r_en` delayed by two cycles: one cycle for the issue register, one for bank read latency. `drain_last` marks the word read from address num_addr-1. Downstream must accept `drain_valid` unconditionally; `drain_ready` is sampled only at issue.
- **Startup.** The init sweeps are not gated by a job, so `done` never fires for them.
- **Exclusions.** Accumulate and drain never use the same bank, guaranteed by swapping only in `D_IDLE`. The for_init port is never used in `A_ACC`/`A_WAIT` except by the drain FSM.

## Timing
- **Reset values.** `w_num`=1 and state `A_INIT1`/`D_IDLE`. All strobes, addresses, `cfg_ready`, `acc_ready`, `drain_valid`, `drain_last` and `done` are 0.
- **Post-reset.** `cfg_ready` rises 2·DEPTH cycles after reset deassertion (64 at default).
- **Accumulate throughput.** One word per cycle; `acc_ready` is a registered state decode.
- **Swap.** Occurs in the cycle after the final accumulate handshake if the drain is idle. `w_num` changes in the next cycle and the first `r_en` can occur that same cycle.
- **Drain latency.** r_en at T, zero-write at T+1, `drain_valid` at T+2. Throughput is one word per cycle with `drain_ready` held.
- **`done` timing.** `done` is asserted the cycle after the last zero-write of the last tile; `cfg_ready` rises the same cycle.
- **Reset mid-operation.** Async abort of everything; the init sweeps restart.

## Test plan
- **Reset and init:** release reset → expect 32 for_init writes with w_num=1 at addresses 0..31, then 32 with w_num=0. `cfg_ready` is high at cycle 64 and no other strobe fires.
- **Single tile:** num_addr=4, pass=2, tile=1, `acc_valid` held → 8 w_en at addresses 0,1,2,3,0,1,2,3. Then w_num toggles to 1 and r_addr runs 0..3. Zero-writes follow one cycle later; `drain_valid` runs 2 cycles after each r_en, with `drain_last` on the 4th; `done` fires once.
- **Overlap:** tile=3, num_addr=8, pass=1 → tile 2 accumulation overlaps tile 1 drain. `w_num` sequence is 0→1→0→1, and banks never coincide.
- **Backpressure:** `drain_ready` toggles 1,0,0,1 → r_addr holds during the low cycles, each drained word appears exactly once, and the swap stalls in `A_WAIT` until the drain completes.
- **Clamping:** cfg_num_addr=40, pass=0 → 32 addresses and 1 pass per tile.
- **Mid-job reset:** assert reset during `D_DRAIN` → all outputs return to 0 asynchronously and the init sweep reruns.

Source files
------------

// File: rtl/psum_gbf_ctrl_if.sv
// Handshake/bus bundle for psum_gbf_ctrl.
//   master : controller side (takes job config and su_adder stream, drives
//            the psum gbf wrapper strobes and the drain stream)
//   slave  : environment side (job source, su_adder, wrapper, drain consumer)
interface psum_gbf_ctrl_if #(
  parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int PASS_BITWIDTH          = 8
);
  logic                              cfg_valid;
  logic                              cfg_ready;
  logic [PSUM_GBF_ADDR_BITWIDTH:0]   cfg_num_addr;
  logic [PASS_BITWIDTH-1:0]          cfg_num_pass;
  logic [PASS_BITWIDTH-1:0]          cfg_num_tile;
  logic                              acc_valid;
  logic                              acc_ready;
  logic                              psum_gbf_w_en;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr;
  logic                              psum_gbf_w_num;
  logic                              psum_gbf_r_en;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr;
  logic                              psum_gbf_w_en_for_init;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr_for_init;
  logic                              drain_ready;
  logic                              drain_valid;
  logic                              drain_last;
  logic                              done;

  modport master (
    input  cfg_valid, cfg_num_addr, cfg_num_pass, cfg_num_tile, acc_valid, drain_ready,
    output cfg_ready, acc_ready, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num,
           psum_gbf_r_en, psum_gbf_r_addr, psum_gbf_w_en_for_init,
           psum_gbf_w_addr_for_init, drain_valid, drain_last, done
  );

  modport slave (
    output cfg_valid, cfg_num_addr, cfg_num_pass, cfg_num_tile, acc_valid, drain_ready,
    input  cfg_ready, acc_ready, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num,
           psum_gbf_r_en, psum_gbf_r_addr, psum_gbf_w_en_for_init,
           psum_gbf_w_addr_for_init, drain_valid, drain_last, done
  );
endinterface

// File: rtl/psum_gbf_ctrl.sv
// Sequencing controller for the ping-pong partial-sum global buffer.
// Zeroes both banks after reset, accumulates the su_adder stream over
// num_addr x num_pass per tile, swaps banks and drains the finished bank
// (zeroing each entry behind its read) while the next tile accumulates.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : psum_gbf_ctrl_if.master (config, accumulate, wrapper, drain)
module psum_gbf_ctrl #(
  parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int PSUM_GBF_DEPTH         = 32,
  parameter int PASS_BITWIDTH          = 8
) (
  input logic             clk,
  input logic             reset,
  psum_gbf_ctrl_if.master bus
);
  localparam int AW = PSUM_GBF_ADDR_BITWIDTH;
  localparam int PW = PASS_BITWIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(PSUM_GBF_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(PSUM_GBF_DEPTH);

  typedef enum logic [2:0] {A_INIT1, A_INIT2, A_IDLE, A_ACC, A_WAIT} a_state_e;
  typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_FLUSH} d_state_e;

  a_state_e a_q, a_d;
  d_state_e d_q, d_d;

  logic [AW-1:0] init_cnt_q, addr_q, dcnt_q, na_m1_q, iaddr_q, iaddr_d;
  logic [PW-1:0] pass_q, tile_q, np_m1_q, nt_m1_q;
  logic          w_num_q, w_num_d, last_tile_q;
  logic          cfg_ready_q, cfg_ready_d, acc_ready_q, acc_ready_d;
  logic          iwe_q, iwe_d, dv_p_q, dv_q, dl_p_q, dl_q, done_q, done_d;
  logic [AW:0]   na_clamp;

  logic cfg_fire, acc_fire, acc_wrap, pass_last, swap, r_en, rd_last, init_sweep, init_end;

  assign cfg_fire   = bus.cfg_valid & cfg_ready_q;
  assign acc_fire   = bus.acc_valid & acc_ready_q;
  assign acc_wrap   = (addr_q == na_m1_q);
  assign pass_last  = (pass_q == np_m1_q);
  // Banks swap only once the previous drain has fully finished.
  assign swap       = (a_q == A_WAIT) & (d_q == D_IDLE);
  // drain_ready is the only issue gate; the consumer absorbs data two cycles on.
  assign r_en       = (d_q == D_DRAIN) & bus.drain_ready;
  assign rd_last    = (dcnt_q == na_m1_q);
  assign init_sweep = (a_q == A_INIT1) | (a_q == A_INIT2);
  assign init_end   = (init_cnt_q == LAST_ADDR);

  always_comb begin
    na_clamp = bus.cfg_num_addr;
    if (bus.cfg_num_addr == '0)          na_clamp = (AW+1)'(1);
    else if (bus.cfg_num_addr > DEPTH_W) na_clamp = DEPTH_W;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= A_INIT1;
      d_q <= D_IDLE;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
    end
  end

  // Next-state logic
  always_comb begin
    a_d = a_q;
    case (a_q)
      A_INIT1: if (init_end) a_d = A_INIT2;
      A_INIT2: if (init_end) a_d = A_IDLE;
      A_IDLE:  if (cfg_fire) a_d = A_ACC;
      A_ACC:   if (acc_fire && acc_wrap && pass_last) a_d = A_WAIT;
      A_WAIT:  if (swap) a_d = (tile_q == nt_m1_q) ? A_IDLE : A_ACC;
      default: a_d = A_INIT1;
    endcase
    d_d = d_q;
    case (d_q)
      D_IDLE:  if (swap) d_d = D_DRAIN;
      D_DRAIN: if (r_en && rd_last) d_d = D_FLUSH;
      D_FLUSH: d_d = D_IDLE;
      default: d_d = D_IDLE;
    endcase
  end

  // Output decode (next values of the registered outputs)
  always_comb begin
    cfg_ready_d = (a_d == A_IDLE) & (d_d == D_IDLE);
    acc_ready_d = (a_d == A_ACC);
    // init sweep and read-behind zeroing share the for_init port; they never overlap
    iwe_d       = init_sweep | r_en;
    iaddr_d     = init_sweep ? init_cnt_q : dcnt_q;
    // FLUSH lasts exactly the cycle of the final zero-write
    done_d      = (d_q == D_FLUSH) & last_tile_q;
    w_num_d     = w_num_q;
    if (a_q == A_INIT2) w_num_d = 1'b0;
    else if (swap)      w_num_d = ~w_num_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt_q  <= '0;
      addr_q      <= '0;
      pass_q      <= '0;
      tile_q      <= '0;
      dcnt_q      <= '0;
      na_m1_q     <= '0;
      np_m1_q     <= '0;
      nt_m1_q     <= '0;
      last_tile_q <= 1'b0;
      w_num_q     <= 1'b1;
      cfg_ready_q <= 1'b0;
      acc_ready_q <= 1'b0;
      iwe_q       <= 1'b0;
      iaddr_q     <= '0;
      dv_p_q      <= 1'b0;
      dv_q        <= 1'b0;
      dl_p_q      <= 1'b0;
      dl_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (init_sweep) init_cnt_q <= init_end ? '0 : init_cnt_q + 1'b1;
      if (cfg_fire) begin
        na_m1_q <= AW'(na_clamp - 1'b1);
        np_m1_q <= (bus.cfg_num_pass == '0) ? '0 : bus.cfg_num_pass - 1'b1;
        nt_m1_q <= (bus.cfg_num_tile == '0) ? '0 : bus.cfg_num_tile - 1'b1;
        addr_q  <= '0;
        pass_q  <= '0;
        tile_q  <= '0;
      end else if (acc_fire) begin
        if (acc_wrap) begin
          addr_q <= '0;
          pass_q <= pass_last ? '0 : pass_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
      if (swap) begin
        tile_q      <= tile_q + 1'b1;
        last_tile_q <= (tile_q == nt_m1_q);
        dcnt_q      <= '0;
      end else if (r_en) begin
        dcnt_q <= dcnt_q + 1'b1;
      end
      w_num_q     <= w_num_d;
      cfg_ready_q <= cfg_ready_d;
      acc_ready_q <= acc_ready_d;
      iwe_q       <= iwe_d;
      iaddr_q     <= iaddr_d;
      // issue register, then bank read latency
      dv_p_q      <= r_en;
      dv_q        <= dv_p_q;
      dl_p_q      <= r_en & rd_last;
      dl_q        <= dl_p_q;
      done_q      <= done_d;
    end
  end

  assign bus.cfg_ready                = cfg_ready_q;
  assign bus.acc_ready                = acc_ready_q;
  assign bus.psum_gbf_w_en            = acc_fire;
  assign bus.psum_gbf_w_addr          = addr_q;
  assign bus.psum_gbf_w_num           = w_num_q;
  assign bus.psum_gbf_r_en            = r_en;
  assign bus.psum_gbf_r_addr          = dcnt_q;
  assign bus.psum_gbf_w_en_for_init   = iwe_q;
  assign bus.psum_gbf_w_addr_for_init = iaddr_q;
  assign bus.drain_valid              = dv_q;
  assign bus.drain_last               = dl_q;
  assign bus.done                     = done_q;
endmodule

// File: tb/tb_psum_gbf_ctrl.sv
// Self-checking bench for psum_gbf_ctrl: directed and randomized jobs
// compared against a transaction-level model of the expected streams.
module tb_psum_gbf_ctrl;
  localparam int AW = 5, DEPTH = 32, PW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  psum_gbf_ctrl_if #(.PSUM_GBF_ADDR_BITWIDTH(AW), .PASS_BITWIDTH(PW)) bus ();

  psum_gbf_ctrl #(.PSUM_GBF_ADDR_BITWIDTH(AW), .PSUM_GBF_DEPTH(DEPTH), .PASS_BITWIDTH(PW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- input drivers ----------------
  int acc_mode = 1, dr_mode = 1, dr_phase = 0;
  int pat[4] = '{1, 0, 0, 1};
  initial begin
    bus.acc_valid = 1'b0;
    bus.drain_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.acc_valid = (acc_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      case (dr_mode)
        1: bus.drain_ready = 1'b1;
        2: bus.drain_ready = ($urandom_range(0, 3) != 0);
        default: begin bus.drain_ready = 1'(pat[dr_phase % 4]); dr_phase++; end
      endcase
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  bit init_done = 0;
  int aw_q[$], rd_q[$], zw_q[$], dl_obs[$];
  int done_cnt = 0, last_zw_cyc = 0, first_aw_cyc = -1, last_aw_cyc = -1, first_rd_cyc = -1;
  logic p1_ren = 0, p2_ren = 0;
  logic [AW-1:0] p1_raddr = '0;

  always @(negedge clk) begin
    if (!reset) begin
      p1_ren = 0; p2_ren = 0; p1_raddr = '0;
    end else begin
      cyc++;
      chk("dv_timing", 32'(bus.drain_valid), 32'(p2_ren));
      if (init_done) begin
        chk("zw_timing", 32'(bus.psum_gbf_w_en_for_init), 32'(p1_ren));
        if (bus.psum_gbf_w_en_for_init) begin
          zw_q.push_back(int'(!bus.psum_gbf_w_num) * 64 + int'(bus.psum_gbf_w_addr_for_init));
          last_zw_cyc = cyc;
          if (p1_ren) chk("zw_addr", 32'(bus.psum_gbf_w_addr_for_init), 32'(p1_raddr));
        end
        if (bus.psum_gbf_w_en) begin
          aw_q.push_back(int'(bus.psum_gbf_w_num) * 64 + int'(bus.psum_gbf_w_addr));
          if (first_aw_cyc < 0) first_aw_cyc = cyc;
          last_aw_cyc = cyc;
        end
        if (bus.psum_gbf_r_en) begin
          rd_q.push_back(int'(!bus.psum_gbf_w_num) * 64 + int'(bus.psum_gbf_r_addr));
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (bus.drain_valid) dl_obs.push_back(int'(bus.drain_last));
        if (bus.done) begin
          done_cnt++;
          chk("done_after_zw", cyc, last_zw_cyc + 1);
          chk("cfg_ready_at_done", 32'(bus.cfg_ready), 1);
        end
      end
      p2_ren = p1_ren;
      p1_ren = bus.psum_gbf_r_en;
      p1_raddr = bus.psum_gbf_r_addr;
    end
  end

  // ---------------- reference model + job runner ----------------
  bit model_wnum = 0;

  task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk(tag, got[i], exp[i]);
  endtask

  task automatic run_job(input int na_raw, input int np_raw, input int nt_raw, input int am, input int dm);
    int na, np, nt, d0, k;
    int exp_aw[$], exp_rd[$], exp_dl[$];
    na = (na_raw == 0) ? 1 : (na_raw > DEPTH) ? DEPTH : na_raw;
    np = (np_raw == 0) ? 1 : np_raw;
    nt = (nt_raw == 0) ? 1 : nt_raw;
    for (int t = 0; t < nt; t++) begin
      for (int p = 0; p < np; p++)
        for (int a = 0; a < na; a++) exp_aw.push_back(int'(model_wnum) * 64 + a);
      for (int a = 0; a < na; a++) begin
        exp_rd.push_back(int'(model_wnum) * 64 + a);
        exp_dl.push_back(int'(a == na - 1));
      end
      model_wnum = ~model_wnum;
    end
    acc_mode = am; dr_mode = dm;
    aw_q.delete(); rd_q.delete(); zw_q.delete(); dl_obs.delete();
    first_aw_cyc = -1; last_aw_cyc = -1; first_rd_cyc = -1;
    d0 = done_cnt;
    k = 0;
    @(negedge clk);
    while (!bus.cfg_ready && k < 2000) begin @(negedge clk); k++; end
    chk("cfg_ready_wait", 32'(bus.cfg_ready), 1);
    bus.cfg_num_addr = (AW+1)'(na_raw);
    bus.cfg_num_pass = PW'(np_raw);
    bus.cfg_num_tile = PW'(nt_raw);
    bus.cfg_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    chk("cfg_ready_drop", 32'(bus.cfg_ready), 0);
    k = 0;
    while (done_cnt == d0 && k < 20000) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, d0 + 1);
    cmp_q("acc_wr", aw_q, exp_aw);
    cmp_q("drain_rd", rd_q, exp_rd);
    cmp_q("zero_wr", zw_q, exp_rd);
    cmp_q("drain_last", dl_obs, exp_dl);
  endtask

  task automatic init_check();
    @(negedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      @(posedge clk); #1;
      chk("init_we", 32'(bus.psum_gbf_w_en_for_init), 1);
      chk("init_addr", 32'(bus.psum_gbf_w_addr_for_init), i % DEPTH);
      chk("init_wnum", 32'(bus.psum_gbf_w_num), 32'(i < DEPTH));
      chk("init_cfg_ready", 32'(bus.cfg_ready), 32'(i == 2 * DEPTH - 1));
      chk("init_quiet", 32'({bus.psum_gbf_w_en, bus.psum_gbf_r_en, bus.drain_valid, bus.done, bus.acc_ready}), 0);
    end
    @(posedge clk); #1;
    chk("init_end_we", 32'(bus.psum_gbf_w_en_for_init), 0);
    chk("init_end_ready", 32'(bus.cfg_ready), 1);
    init_done = 1;
    model_wnum = 0;
  endtask

  task automatic reset_state_check(input string tag);
    chk({tag, "_wnum"}, 32'(bus.psum_gbf_w_num), 1);
    chk({tag, "_strobes"}, 32'({bus.psum_gbf_w_en, bus.psum_gbf_r_en, bus.psum_gbf_w_en_for_init,
                                bus.cfg_ready, bus.acc_ready, bus.drain_valid, bus.drain_last, bus.done}), 0);
    chk({tag, "_addrs"}, 32'({bus.psum_gbf_w_addr, bus.psum_gbf_r_addr, bus.psum_gbf_w_addr_for_init}), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bus.cfg_valid = 1'b0;
    bus.cfg_num_addr = '0;
    bus.cfg_num_pass = '0;
    bus.cfg_num_tile = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_state_check("reset");
    init_check();

    // single tile, acc_valid held: throughput and swap latency
    run_job(4, 2, 1, 1, 1);
    chk("acc_burst_len", last_aw_cyc - first_aw_cyc, 7);
    chk("swap_to_read", first_rd_cyc - last_aw_cyc, 2);

    // overlap of accumulate and drain across three tiles
    run_job(8, 1, 3, 1, 1);
    // drain backpressure 1,0,0,1 with bursty accumulate
    run_job(6, 2, 2, 2, 3);
    // clamping: 40 addresses -> DEPTH, 0 passes -> 1
    run_job(40, 0, 1, 1, 1);
    // random jobs
    for (int j = 0; j < 3; j++)
      run_job($urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(0, 3), 2, 2);

    // mid-job reset during the drain
    acc_mode = 1; dr_mode = 1;
    bus.cfg_num_addr = 6'd8; bus.cfg_num_pass = 8'd2; bus.cfg_num_tile = 8'd2;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    @(posedge clk); #1 bus.cfg_valid = 1'b0;
    k = 0;
    while (!bus.psum_gbf_r_en && k < 500) begin @(negedge clk); k++; end
    chk("drain_reached", 32'(bus.psum_gbf_r_en), 1);
    @(posedge clk); #2 reset = 1'b0;
    #1 reset_state_check("midreset");
    init_done = 0;
    repeat (2) @(posedge clk);
    init_check();
    run_job(3, 1, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
